dram_perf_seq: RTL and testbench

- Test sequencer directly upstream of the DRAM burst controller in the DRAM perf CL.
- Latches a programmed job: mode, start address in 64B-line units, burst length in beats minus one, write pattern and iteration count.
- Drives the controller's level-held rd_enable/wr_enable handshake for the programmed number of write and/or read passes.
- Accumulates per-phase cycle counts for host readout.

---
 rtl/dram_perf_pkg.sv | 13 +
 rtl/dram_perf_seq_perf_sat_cnt.sv | 15 +
 rtl/dram_perf_seq.sv | 91 +++++++++
 tb/tb_dram_perf_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dram_perf_pkg.sv
// dram_perf_pkg: shared mode encoding, sequencer states and default widths for the DRAM perf sequencer.
package dram_perf_pkg;
  localparam int CNT_W_DEF = 64;
  localparam int ITER_W_DEF = 16;
  typedef enum logic [1:0] {MODE_NONE, MODE_WR, MODE_RD, MODE_WR_RD} mode_t;
  typedef enum logic [2:0] {IDLE, ARM, WR_REQ, WR_REL, RD_REQ, RD_REL, NEXT, FIN} state_t;
  function automatic logic has_wr(mode_t m);
    return m == MODE_WR || m == MODE_WR_RD;
  endfunction
  function automatic logic has_rd(mode_t m);
    return m == MODE_RD || m == MODE_WR_RD;
  endfunction
endpackage

// File: rtl/dram_perf_seq_perf_sat_cnt.sv
// perf_sat_cnt: clearable, enabled up-counter that sticks at all-ones instead of wrapping.
module perf_sat_cnt #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (en && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/dram_perf_seq.sv
// dram_perf_seq: runs programmed write/read passes against the DRAM burst controller and times each phase.
module dram_perf_seq
  import dram_perf_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ITER_W = ITER_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        cfg_mode,
  input  logic [31:0]       cfg_addr,
  input  logic [31:0]       cfg_len,
  input  logic [31:0]       cfg_val,
  input  logic [ITER_W-1:0] cfg_iter,
  output logic              wr_enable,
  output logic              rd_enable,
  output logic [31:0]       start_addr,
  output logic [31:0]       burst_len,
  output logic [31:0]       write_val,
  input  logic              wr_done,
  input  logic              rd_done,
  output logic              busy,
  output logic              job_done,
  output logic              aborted,
  output logic [CNT_W-1:0]  wr_cycles,
  output logic [CNT_W-1:0]  rd_cycles,
  output logic [ITER_W-1:0] iter_done
);
  state_t state, nxt;
  mode_t mode;
  logic [ITER_W-1:0] iters;
  logic pend, accept, last;
  assign accept = state == IDLE && start;
  assign last = pend || abort || (iter_done + 1'b1 == iters);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? ARM : IDLE;
      ARM:     if (!wr_done && !rd_done) nxt = has_wr(mode) ? WR_REQ : has_rd(mode) ? RD_REQ : FIN;
      WR_REQ:  if (wr_done) nxt = WR_REL;
      WR_REL:  if (!wr_done) nxt = has_rd(mode) ? RD_REQ : NEXT;
      RD_REQ:  if (rd_done) nxt = RD_REL;
      RD_REL:  if (!rd_done) nxt = NEXT;
      NEXT:    nxt = last ? FIN : ARM;
      default: nxt = IDLE;
    endcase
  end
  // Enables and status are registered copies of the next state, so they never glitch.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mode <= MODE_NONE;
      iters <= '0;
      pend <= 1'b0;
      wr_enable <= 1'b0;
      rd_enable <= 1'b0;
      busy <= 1'b0;
      job_done <= 1'b0;
      aborted <= 1'b0;
      iter_done <= '0;
      start_addr <= '0;
      burst_len <= '0;
      write_val <= '0;
    end else begin
      state <= nxt;
      wr_enable <= nxt == WR_REQ;
      rd_enable <= nxt == RD_REQ;
      busy <= nxt != IDLE && nxt != FIN;
      job_done <= nxt == FIN;
      if (state != IDLE && state != FIN && abort) pend <= 1'b1;
      if (state == FIN) pend <= 1'b0;
      if (state == NEXT) begin
        if (!(&iter_done)) iter_done <= iter_done + 1'b1;
        if (last) aborted <= pend || abort;
      end
      if (accept) begin
        mode <= mode_t'(cfg_mode);
        iters <= cfg_iter == '0 ? ITER_W'(1) : cfg_iter;
        start_addr <= cfg_addr;
        burst_len <= cfg_len;
        write_val <= cfg_val;
        iter_done <= '0;
        aborted <= 1'b0;
        pend <= 1'b0;
      end
    end
  perf_sat_cnt #(.W(CNT_W)) u_wr_cnt (.clk(clk), .rst_n(rst_n), .clr(accept), .en(state == WR_REQ), .q(wr_cycles));
  perf_sat_cnt #(.W(CNT_W)) u_rd_cnt (.clk(clk), .rst_n(rst_n), .clr(accept), .en(state == RD_REQ), .q(rd_cycles));
endmodule

// File: tb/tb_dram_perf_seq.sv
// tb_dram_perf_seq: scoreboard bench with a fixed-latency controller model; a 4-bit-counter twin checks saturation.
module tb_dram_perf_seq;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, stuck = 0;
  logic [1:0] cfg_mode = 0;
  logic [31:0] cfg_addr = 0, cfg_len = 0, cfg_val = 0;
  logic [15:0] cfg_iter = 0;
  logic wr_enable, rd_enable, busy, job_done, aborted, wr_done, rd_done;
  logic [31:0] start_addr, burst_len, write_val;
  logic [63:0] wr_cycles, rd_cycles;
  logic [15:0] iter_done;
  logic e4w, e4r, b4, j4, a4;
  logic [31:0] sa4, bl4, wv4;
  logic [3:0] wc4, rc4;
  logic [15:0] it4;
  always #5 clk = ~clk;

  dram_perf_seq #(.CNT_W(64), .ITER_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_mode(cfg_mode), .cfg_addr(cfg_addr),
    .cfg_len(cfg_len), .cfg_val(cfg_val), .cfg_iter(cfg_iter), .wr_enable(wr_enable), .rd_enable(rd_enable),
    .start_addr(start_addr), .burst_len(burst_len), .write_val(write_val), .wr_done(wr_done), .rd_done(rd_done),
    .busy(busy), .job_done(job_done), .aborted(aborted), .wr_cycles(wr_cycles), .rd_cycles(rd_cycles),
    .iter_done(iter_done));
  dram_perf_seq #(.CNT_W(4), .ITER_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_mode(cfg_mode), .cfg_addr(cfg_addr),
    .cfg_len(cfg_len), .cfg_val(cfg_val), .cfg_iter(cfg_iter), .wr_enable(e4w), .rd_enable(e4r),
    .start_addr(sa4), .burst_len(bl4), .write_val(wv4), .wr_done(wr_done), .rd_done(rd_done),
    .busy(b4), .job_done(j4), .aborted(a4), .wr_cycles(wc4), .rd_cycles(rc4), .iter_done(it4));

  // Controller model: done rises lat cycles into a held enable and falls once the enable drops.
  int lat = 10, wcnt, rcnt;
  logic wd, rdn;
  assign wr_done = wd | stuck;
  assign rd_done = rdn;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wd <= 0; rdn <= 0; wcnt <= 0; rcnt <= 0;
    end else begin
      if (!wr_enable) begin wd <= 0; wcnt <= 0; end
      else if (!wd) begin wcnt <= wcnt + 1; if (wcnt == lat - 1) wd <= 1; end
      if (!rd_enable) begin rdn <= 0; rcnt <= 0; end
      else if (!rdn) begin rcnt <= rcnt + 1; if (rcnt == lat - 1) rdn <= 1; end
    end

  typedef struct {int iter; longint unsigned wr, rd; int wr4, rd4; bit ab; int whs, rhs; logic [31:0] a, l, v;} exp_t;
  typedef struct {string n; int sel; longint unsigned e;} probe_t;
  exp_t sb[$];
  probe_t pq[$];
  int errors = 0, checks = 0, whs = 0, rhs = 0;
  logic pw = 0, pr = 0;

  function automatic void chk(string n, longint unsigned a, longint unsigned e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction

  function automatic longint unsigned pv(int s);
    case (s)
      0: return busy;
      1: return wr_enable;
      2: return rd_enable;
      3: return wr_cycles;
      4: return rd_cycles;
      5: return iter_done;
      6: return job_done;
      7: return aborted;
      default: return sb.size();
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    exp_t x;
    probe_t p;
    chk("enables_exclusive", wr_enable && rd_enable, 0);
    if (wr_enable && !pw) whs++;
    if (rd_enable && !pr) rhs++;
    pw = wr_enable;
    pr = rd_enable;
    while (pq.size() > 0) begin
      p = pq.pop_front();
      chk(p.n, pv(p.sel), p.e);
    end
    if (job_done) begin
      chk("sb_has_entry", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("iter_done", iter_done, x.iter);
        chk("wr_cycles", wr_cycles, x.wr);
        chk("rd_cycles", rd_cycles, x.rd);
        chk("wr_cycles_sat4", wc4, x.wr4);
        chk("rd_cycles_sat4", rc4, x.rd4);
        chk("aborted", aborted, x.ab);
        chk("wr_handshakes", whs, x.whs);
        chk("rd_handshakes", rhs, x.rhs);
        chk("start_addr", start_addr, x.a);
        chk("burst_len", burst_len, x.l);
        chk("write_val", write_val, x.v);
      end
    end
  end

  function automatic void probe(string n, int s, longint unsigned e);
    pq.push_back('{n, s, e});
  endfunction

  function automatic void expect_job(int it, longint unsigned w, longint unsigned r, bit ab, int nw, int nr,
                                     logic [31:0] a, logic [31:0] l, logic [31:0] v);
    sb.push_back('{it, w, r, int'(w > 15 ? 15 : w), int'(r > 15 ? 15 : r), ab, whs + nw, rhs + nr, a, l, v});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [1:0] m, input logic [31:0] a, input logic [31:0] l, input logic [31:0] v,
                    input logic [15:0] it);
    cfg_mode = m; cfg_addr = a; cfg_len = l; cfg_val = v; cfg_iter = it;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!job_done && n < budget) begin tick(); n++; end
    if (!job_done) probe("done_timeout", 0, 0);
    tick();
  endtask

  task automatic wait_hs(input bit rd, input int target, input int budget);
    int n = 0;
    while ((rd ? rhs : whs) < target && n < budget) begin tick(); n++; end
    if ((rd ? rhs : whs) < target) probe("handshake_timeout", 0, 0);
  endtask

  initial begin
    int b;
    repeat (3) tick();
    probe("rst_busy", 0, 0); probe("rst_wr_enable", 1, 0); probe("rst_rd_enable", 2, 0);
    probe("rst_wr_cycles", 3, 0); probe("rst_rd_cycles", 4, 0); probe("rst_iter_done", 5, 0);
    probe("rst_job_done", 6, 0); probe("rst_aborted", 7, 0);
    tick();
    rst_n = 1;
    tick();
    expect_job(1, 11, 11, 0, 1, 1, 0, 3, 32'hA5A5A5A5);
    go(3, 0, 3, 32'hA5A5A5A5, 1);
    wait_done(200);
    expect_job(4, 0, 44, 0, 0, 4, 32'h100, 0, 0);
    go(2, 32'h100, 0, 0, 4);
    wait_done(400);
    expect_job(3, 33, 33, 1, 3, 3, 32'h20, 7, 32'h12345678);
    b = whs;
    go(3, 32'h20, 7, 32'h12345678, 100);
    repeat (5) tick();
    go(1, 32'hDEAD, 1, 1, 5);
    wait_hs(0, b + 3, 500);
    repeat (3) tick();
    abort = 1;
    tick();
    abort = 0;
    wait_done(500);
    expect_job(0, 0, 0, 0, 0, 0, 0, 0, 0);
    go(0, 0, 0, 0, 1);
    probe("m0_done_early", 6, 0); probe("m0_busy_arm", 0, 1);
    tick();
    probe("m0_done_at_2", 6, 1); probe("m0_busy_fin", 0, 0);
    tick(); tick();
    lat = 30;
    expect_job(1, 31, 0, 0, 1, 0, 4, 1, 32'hFFFF0000);
    go(1, 4, 1, 32'hFFFF0000, 0);
    wait_done(300);
    lat = 10;
    stuck = 1;
    expect_job(1, 11, 0, 0, 1, 0, 8, 2, 32'h55);
    go(1, 8, 2, 32'h55, 1);
    repeat (20) tick();
    probe("stuck_busy", 0, 1); probe("stuck_wr_enable", 1, 0); probe("stuck_wr_cycles", 3, 0);
    tick();
    stuck = 0;
    wait_done(200);
    b = rhs;
    go(2, 32'h40, 3, 0, 1);
    wait_hs(1, b + 1, 100);
    repeat (3) tick();
    rst_n = 0;
    probe("arst_rd_enable", 2, 0); probe("arst_busy", 0, 0); probe("arst_rd_cycles", 4, 0); probe("arst_iter", 5, 0);
    tick(); tick();
    rst_n = 1;
    tick();
    expect_job(2, 22, 22, 0, 2, 2, 32'h80, 15, 32'hCAFEF00D);
    go(3, 32'h80, 15, 32'hCAFEF00D, 2);
    wait_done(400);
    probe("sb_left", 8, 0);
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
